calc_op_scheduler: RTL and testbench
====================================

// Module: calc_op_scheduler
// PURPOSE
//  Round-robin scheduler sharing one multi-cycle calculator datapath (ADD/SUB/MUL/DIV) among N requesters.
//  Accepts one operation at a time, screens divide-by-zero, issues a start pulse and waits for done with a timeout.
//  Returns the result to the owning requester over a valid/ready handshake.
//  Sits between the front-end input sources (switch/button panel, serial port, ...) and the datapath.
// PARAMETERS
//  N        4      number of requesters (2..8)
//  W        16     operand width; result width is W+1 (MSB = carry/overflow bit)
//  TIMEOUT  70000  max cycles in WAIT before forcing an error response (must exceed worst-case MUL, 2^W-1)
// PORTS
//  Clk        in   1       clock
//  Reset      in   1       asynchronous, active-high reset
//  Req        in   N       per-requester request; held with operands until Gnt
//  ReqA       in   N*W     operand A, requester i at [i*W +: W]
//  ReqB       in   N*W     operand B, same packing
//  ReqOp      in   N*2     opcode, requester i at [2i +: 2] (calc_pkg encoding)
//  Gnt        out  N       one-hot, one-cycle pulse: request accepted, operands captured
//  RspValid   out  N       one-hot, held until matching RspReady
//  RspReady   in   N       per-requester response accept
//  RspC       out  W+1     result (valid while any RspValid)
//  RspFlag    out  1       datapath overflow/inexact flag
//  RspErr     out  1       1 = divide-by-zero or timeout; RspC = 0 when set
//  AluStart   out  1       one-cycle start pulse to datapath
//  AluA/AluB  out  W       captured operands, stable from ISSUE through end of WAIT
//  AluOp      out  2       captured opcode
//  AluDone    in   1       datapath completion pulse
//  AluC       in   W+1     datapath result, sampled on AluDone
//  AluFlag    in   1       datapath flag, sampled on AluDone
//  Busy       out  1       state != IDLE
//  QIdle,QIssue,QWait,QResp  out 1 each  one-hot state, for LEDs/debug
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0; Gnt, RspValid, AluStart, RspC, RspFlag, RspErr, AluA, AluB, AluOp, Busy all 0.
//   Mid-operation reset abandons the op; no response is produced.
//  One-hot FSM IDLE->ISSUE->WAIT->RESP->IDLE; all outputs registered.
//  IDLE: if |Req, own = first set bit at or after ptr (cyclic). Capture A/B/Op[own], pulse Gnt[own].
//   If Op==DIV && B==0: go to RESP with RspErr=1, RspC=0, RspFlag=0; datapath is never started.
//   Otherwise go to ISSUE.
//  ISSUE (1 cycle): AluStart=1; load timeout counter with TIMEOUT; go to WAIT.
//  WAIT: on AluDone, RspC<=AluC, RspFlag<=AluFlag, RspErr<=0; go to RESP.
//   Else decrement counter; on reaching 0, RspErr=1, RspC=0; go to RESP.
//  RESP: RspValid[own]=1. When RspReady[own]=1: drop RspValid, ptr<=own+1 mod N, go to IDLE.
//   RspReady on other bits is ignored.
//  Latency, Req to AluStart: 2 edges. Minimum op round trip with AluDone immediately after start: 5 cycles.
//  Back-to-back: a new grant is possible the cycle after RESP exits, so there is no idle gap beyond IDLE.
//  AluDone outside WAIT is ignored. AluDone on the same cycle the timeout expires: AluDone wins (no error).
//  Requests arriving during non-IDLE states wait. Dropping Req before Gnt is legal (request withdrawn).
//  Fairness: each active requester is granted within N grants.
// STRUCTURE
//  calc_pkg: opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
//   state encodings; W default.
//  Sub-module rr_arbiter (N): inputs req, ptr; outputs one-hot grant and grant index; purely combinational.
//  Top holds the FSM, operand/result registers, the timeout counter ($clog2(TIMEOUT+1) bits) and ptr.
// TESTING
//  1 Req[0] ADD A=5 B=7, AluDone 3 cycles after AluStart with AluC=12 -> Gnt[0], AluStart once, RspValid[0], RspC=12, RspErr=0.
//  2 Req[1] DIV A=9 B=0 -> Gnt[1], no AluStart, RspValid[1] with RspErr=1, RspC=0.
//  3 Req=4'b1111 held, RspReady always 1 -> grant order 0,1,2,3,0; ptr wraps from 3 to 0.
//  4 TIMEOUT=10, MUL with AluDone never asserted -> RspValid with RspErr=1 exactly 10 WAIT cycles after AluStart.
//  5 Reset asserted during WAIT -> all outputs 0 at once. A later AluDone is ignored; the next Req[2] is granted normally.
//  6 RspReady held low for 20 cycles in RESP -> RspValid and RspC stable. A stray AluDone and Req[3] have no effect until accepted.

Source files
------------

// File: rtl/calc_op_scheduler_pkg.sv
// Shared definitions for the calculator operation scheduler.
// Opcodes, one-hot FSM states and default sizing.
package calc_op_scheduler_pkg;

    localparam int N_DEF       = 4;
    localparam int W_DEF       = 16;
    localparam int TIMEOUT_DEF = 70000;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    // A divide with a zero divisor is answered without touching the datapath.
    function automatic logic is_div0(input logic [1:0] op,
                                     input logic       b_zero);
        return (op == OP_DIV) && b_zero;
    endfunction

endpackage

// File: rtl/calc_op_scheduler_if.sv
// Requester and datapath signal bundle of the scheduler.
// slave = scheduler side, master = front-end/datapath side.
interface calc_op_scheduler_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [N-1:0]   Req;
    logic [N*W-1:0] ReqA;
    logic [N*W-1:0] ReqB;
    logic [N*2-1:0] ReqOp;
    logic [N-1:0]   Gnt;
    logic [N-1:0]   RspValid;
    logic [N-1:0]   RspReady;
    logic [W:0]     RspC;
    logic           RspFlag;
    logic           RspErr;
    logic           AluStart;
    logic [W-1:0]   AluA;
    logic [W-1:0]   AluB;
    logic [1:0]     AluOp;
    logic           AluDone;
    logic [W:0]     AluC;
    logic           AluFlag;
    logic           Busy;
    logic           QIdle;
    logic           QIssue;
    logic           QWait;
    logic           QResp;

    modport slave (
        input  Req, ReqA, ReqB, ReqOp, RspReady,
        input  AluDone, AluC, AluFlag,
        output Gnt, RspValid, RspC, RspFlag, RspErr,
        output AluStart, AluA, AluB, AluOp,
        output Busy, QIdle, QIssue, QWait, QResp
    );

    modport master (
        output Req, ReqA, ReqB, ReqOp, RspReady,
        output AluDone, AluC, AluFlag,
        input  Gnt, RspValid, RspC, RspFlag, RspErr,
        input  AluStart, AluA, AluB, AluOp,
        input  Busy, QIdle, QIssue, QWait, QResp
    );

endinterface

// File: rtl/calc_op_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Returns a one-hot grant, its index and whether anything was found.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Walk the requesters cyclically starting from ptr; first hit wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/calc_op_scheduler.sv
// Round-robin scheduler sharing one multi-cycle calculator datapath.
// One op in flight; divide-by-zero screening and a WAIT timeout.
module calc_op_scheduler
    import calc_op_scheduler_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic Clk,
    input logic Reset,
    calc_op_scheduler_if.slave bus
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] own;
    logic [N-1:0]  own_oh;
    logic [CW-1:0] cnt;

    logic [N-1:0]  arb_gnt;
    logic [PW-1:0] arb_idx;
    logic          arb_any;

    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic [1:0]    sel_op;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req   (bus.Req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Operands of the requester the arbiter currently picks.
    always_comb begin
        sel_a  = bus.ReqA[arb_idx*W +: W];
        sel_b  = bus.ReqB[arb_idx*W +: W];
        sel_op = bus.ReqOp[arb_idx*2 +: 2];
    end

    assign {bus.QResp, bus.QWait, bus.QIssue, bus.QIdle} = state;
    assign bus.Busy = (state != S_IDLE);

    // Scheduler FSM with registered grant, datapath and response outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            own          <= '0;
            own_oh       <= '0;
            cnt          <= '0;
            bus.Gnt      <= '0;
            bus.RspValid <= '0;
            bus.RspC     <= '0;
            bus.RspFlag  <= 1'b0;
            bus.RspErr   <= 1'b0;
            bus.AluStart <= 1'b0;
            bus.AluA     <= '0;
            bus.AluB     <= '0;
            bus.AluOp    <= '0;
        end else begin
            bus.Gnt      <= '0;
            bus.AluStart <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        own       <= arb_idx;
                        own_oh    <= arb_gnt;
                        bus.Gnt   <= arb_gnt;
                        bus.AluA  <= sel_a;
                        bus.AluB  <= sel_b;
                        bus.AluOp <= sel_op;
                        if (is_div0(sel_op, sel_b == '0)) begin
                            bus.RspErr   <= 1'b1;
                            bus.RspC     <= '0;
                            bus.RspFlag  <= 1'b0;
                            bus.RspValid <= arb_gnt;
                            state        <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    bus.AluStart <= 1'b1;
                    cnt          <= CW'(TIMEOUT);
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.AluDone) begin
                        bus.RspC     <= bus.AluC;
                        bus.RspFlag  <= bus.AluFlag;
                        bus.RspErr   <= 1'b0;
                        bus.RspValid <= own_oh;
                        state        <= S_RESP;
                    end else if (cnt <= CW'(1)) begin
                        bus.RspC     <= '0;
                        bus.RspFlag  <= 1'b0;
                        bus.RspErr   <= 1'b1;
                        bus.RspValid <= own_oh;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.RspReady[own]) begin
                        bus.RspValid <= '0;
                        ptr          <= (own == PW'(N - 1)) ? '0 : own + 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Randomized bench for calc_op_scheduler with a transaction-level model.
// The bench plays front-end requesters and the calculator datapath.
module tb_calc_op_scheduler;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 10;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    int n_vec = 0;
    int n_bad = 0;
    int mptr  = 0;

    logic [1:0]   opc [N];
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    calc_op_scheduler_if #(.N(N), .W(W)) bus();

    calc_op_scheduler #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Datapath behaviour the bench emulates.
    function automatic logic [W:0] calc(input logic [1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            2'd0: return {1'b0, a} + {1'b0, b};
            2'd1: return {1'b0, a} - {1'b0, b};
            2'd2: begin p = a * b; return p[W:0]; end
            default: return (b == 0) ? '0 : {1'b0, a / b};
        endcase
    endfunction

    // Round-robin rule: first active requester at or after the pointer.
    function automatic int pick(input logic [N-1:0] mask, input int p);
        for (int k = 0; k < N; k++)
            if (mask[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.ReqA[i*W +: W]  = opa[i];
            bus.ReqB[i*W +: W]  = opb[i];
            bus.ReqOp[i*2 +: 2] = opc[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            opc[i] = 2'($urandom_range(0, 3));
            opa[i] = W'($urandom);
            opb[i] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        end
    endtask

    // One transaction: grant, optional datapath run, response handshake.
    // dly: cycles after AluStart before AluDone; > TMO-1 means timeout.
    task automatic run_txn(input logic [N-1:0] mask, input int dly,
                           input int hold);
        int own;
        logic [W:0] res;
        logic [W:0] exp_c;
        logic flg;
        bit div0;
        bit err;
        own = pick(mask, mptr);
        drive_ops();
        bus.Req = mask;
        tick();
        chk("gnt", bus.Gnt, 32'(1 << own));
        bus.Req[own] = 1'b0;
        div0 = (opc[own] == 2'd3) && (opb[own] == 0);
        res  = calc(opc[own], opa[own], opb[own]);
        flg  = 1'($urandom);
        if (div0) begin
            err = 1'b1;
            chk("div0_start", bus.AluStart, 0);
        end else begin
            chk("issue_start", bus.AluStart, 0);
            tick();
            chk("start", bus.AluStart, 1);
            chk("alu_a", bus.AluA, opa[own]);
            chk("alu_b", bus.AluB, opb[own]);
            chk("alu_op", bus.AluOp, opc[own]);
            err = (dly + 1 > TMO);
            for (int k = 1; k <= TMO; k++) begin
                if (k == dly + 1) begin
                    bus.AluDone = 1'b1;
                    bus.AluC    = res;
                    bus.AluFlag = flg;
                end
                tick();
                bus.AluDone = 1'b0;
                if (k == dly + 1 || k == TMO) break;
                chk("wait_valid", bus.RspValid, 0);
                chk("wait_start", bus.AluStart, 0);
            end
        end
        exp_c = err ? '0 : res;
        chk("rsp_valid", bus.RspValid, 32'(1 << own));
        chk("rsp_err", bus.RspErr, err);
        chk("rsp_c", bus.RspC, exp_c);
        if (!err) chk("rsp_flag", bus.RspFlag, flg);
        if (div0) chk("div0_flag", bus.RspFlag, 0);
        for (int h = 0; h < hold; h++) begin
            bus.RspReady = N'($urandom) & ~(N'(1) << own);
            bus.AluDone  = 1'($urandom);
            bus.AluC     = (W+1)'($urandom);
            tick();
            bus.AluDone = 1'b0;
            chk("hold_valid", bus.RspValid, 32'(1 << own));
            chk("hold_c", bus.RspC, exp_c);
            chk("hold_gnt", bus.Gnt, 0);
        end
        bus.RspReady = N'(1) << own;
        tick();
        bus.RspReady = '0;
        chk("done_valid", bus.RspValid, 0);
        chk("done_idle", bus.QIdle, 1);
        mptr = (own + 1) % N;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, bus.Gnt, 0);
        chk({tag, "_valid"}, bus.RspValid, 0);
        chk({tag, "_start"}, bus.AluStart, 0);
        chk({tag, "_c"}, bus.RspC, 0);
        chk({tag, "_flagerr"}, {bus.RspFlag, bus.RspErr}, 0);
        chk({tag, "_ab"}, {bus.AluA, bus.AluB}, 0);
        chk({tag, "_op"}, bus.AluOp, 0);
        chk({tag, "_busy"}, bus.Busy, 0);
        chk({tag, "_state"}, {bus.QResp, bus.QWait, bus.QIssue, bus.QIdle}, 1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        chk_zero("reset");
        Reset = 1'b0;
        mptr = 0;
    endtask

    initial begin
        bus.Req      = '0;
        bus.ReqA     = '0;
        bus.ReqB     = '0;
        bus.ReqOp    = '0;
        bus.RspReady = '0;
        bus.AluDone  = 1'b0;
        bus.AluC     = '0;
        bus.AluFlag  = 1'b0;
        rand_ops();
        tick();
        do_reset();

        // ADD 5+7 on requester 0, done 3 cycles after start
        opc[0] = 2'd0; opa[0] = 16'd5; opb[0] = 16'd7;
        run_txn(4'b0001, 3, 0);

        // DIV 9/0 on requester 1: screened, never started
        opc[1] = 2'd3; opa[1] = 16'd9; opb[1] = 16'd0;
        run_txn(4'b0010, 0, 1);

        // All requesting: order 0,1,2,3,0 from a fresh pointer
        do_reset();
        rand_ops();
        for (int i = 0; i < N; i++) opb[i] = 16'd3;
        for (int t = 0; t < 5; t++) run_txn(4'b1111, 1, 0);

        // MUL with no completion: timeout after TMO wait cycles
        opc[0] = 2'd2; opa[0] = 16'd300; opb[0] = 16'd200;
        run_txn(4'b0001, TMO + 5, 0);

        // Completion on the last wait cycle beats the timeout
        opc[1] = 2'd1; opa[1] = 16'd1; opb[1] = 16'd2;
        run_txn(4'b0010, TMO - 1, 0);

        // Reset during WAIT abandons the op
        opc[0] = 2'd2; opb[0] = 16'd4;
        drive_ops();
        bus.Req = 4'b0001;
        tick();
        bus.Req = '0;
        tick();
        tick();
        chk("pre_reset_wait", bus.QWait, 1);
        Reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        mptr = 0;
        bus.AluDone = 1'b1;
        bus.AluC = 17'h155;
        tick();
        bus.AluDone = 1'b0;
        chk("late_done_valid", bus.RspValid, 0);
        chk("late_done_busy", bus.Busy, 0);
        opc[2] = 2'd0; opb[2] = 16'd1;
        run_txn(4'b0100, 0, 0);

        // Long hold in RESP with stray done and a waiting Req[3]
        opc[0] = 2'd0; opb[0] = 16'd9;
        mptr = 0;
        do_reset();
        run_txn(4'b1001, 2, 20);
        run_txn(4'b1000, 0, 0);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            logic [N-1:0] m;
            rand_ops();
            m = N'($urandom_range(1, (1 << N) - 1));
            run_txn(m, $urandom_range(0, TMO + 2), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
